cp0_timer_intc: RTL and testbench

// - Interrupt source stage directly upstream of the CP0 coprocessor: owns Count/Compare timer and

---
 rtl/cp0_pkg.sv | 17 +
 rtl/irq_sync.sv | 25 ++
 rtl/cp0_timer_intc.sv | 145 ++++++++++++++
 tb/tb_cp0_timer_intc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants and the interrupt-request FSM state type.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam int         IP_TIMER        = 7;
  localparam int         IP_EXT_LO       = 2;
  localparam logic [4:0] EXC_INT         = 5'b00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } intc_state_t;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt lines.
module irq_sync #(
  parameter int N_EXT       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EXT-1:0] irq_ext,
  output logic [N_EXT-1:0] levels
);

  logic [N_EXT-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= irq_ext;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign levels = stage[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer plus external IRQ masking; raises a held request
// to the controller and tracks it through acknowledge and eret.
module cp0_timer_intc
  import cp0_pkg::*;
#(
  parameter int PRESCALE    = 2,
  parameter int N_EXT       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      status,
  input  logic [4:0]       cp0_rd,
  input  logic [31:0]      cp0_wdata,
  input  logic             mtc0,
  input  logic             eret,
  input  logic [N_EXT-1:0] irq_ext,
  input  logic             intr_ack,
  output logic             intr_req,
  output logic [7:0]       ip,
  output logic             timer_int,
  output logic [31:0]      rdata,
  output logic             rd_hit
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    pre;
  logic [31:0]      count;
  logic [31:0]      compare;
  logic             pending;
  logic             match;
  logic             match_d;
  logic             tick;
  logic             wr_count;
  logic             wr_compare;
  logic             any;
  logic [N_EXT-1:0] ext_lvl;
  intc_state_t      state;
  intc_state_t      state_next;
  logic             unused_status_bits;

  assign unused_status_bits = ^{status[31:16], status[7:1]};

  assign wr_count   = mtc0 && (cp0_rd == CP0_REG_COUNT);
  assign wr_compare = mtc0 && (cp0_rd == CP0_REG_COMPARE);
  assign tick       = (pre == PW'(PRESCALE - 1));
  assign match      = (count == compare);

  // A Count write restarts the prescaler so the written value is held a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      count <= '0;
    end else if (wr_count) begin
      pre   <= '0;
      count <= cp0_wdata;
    end else if (tick) begin
      pre   <= '0;
      count <= count + 32'd1;
    end else begin
      pre   <= pre + 1'b1;
    end
  end

  // match_d resets high so a power-on equality never fires the timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= 32'hFFFF_FFFF;
      pending <= 1'b0;
      match_d <= 1'b1;
    end else begin
      match_d <= match;
      if (wr_compare) begin
        compare <= cp0_wdata;
        pending <= 1'b0;
      end else if (match && !match_d) begin
        pending <= 1'b1;
      end
    end
  end

  irq_sync #(
    .N_EXT       (N_EXT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .irq_ext (irq_ext),
    .levels  (ext_lvl)
  );

  always_comb begin
    ip                       = '0;
    ip[IP_TIMER]             = pending;
    ip[IP_EXT_LO +: N_EXT]   = ext_lvl;
  end

  assign timer_int = ip[IP_TIMER];
  assign any       = status[0] && (|(ip & status[15:8]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      intr_req <= 1'b0;
    end else begin
      state    <= state_next;
      intr_req <= (state_next == REQ);
    end
  end

  // SERV ignores any so the handler cannot be re-entered before eret.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (any) state_next = REQ;
      REQ: begin
        if (intr_ack)  state_next = SERV;
        else if (!any) state_next = IDLE;
      end
      SERV: if (eret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata  = '0;
    rd_hit = 1'b0;
    case (cp0_rd)
      CP0_REG_COUNT: begin
        rdata  = count;
        rd_hit = 1'b1;
      end
      CP0_REG_COMPARE: begin
        rdata  = compare;
        rd_hit = 1'b1;
      end
      default: begin
        rdata  = '0;
        rd_hit = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed plus randomized bench for cp0_timer_intc against an arithmetic reference model.
module tb_cp0_timer_intc;

  localparam int P  = 2;
  localparam int NX = 5;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   status;
  logic [4:0]    cp0_rd;
  logic [31:0]   cp0_wdata;
  logic          mtc0;
  logic          eret;
  logic [NX-1:0] irq_ext;
  logic          intr_ack;
  logic          intr_req;
  logic [7:0]    ip;
  logic          timer_int;
  logic [31:0]   rdata;
  logic          rd_hit;

  int total = 0;
  int bad   = 0;

  // Model: Count is base plus elapsed cycles / PRESCALE since the last Count write.
  logic [31:0]   m_base;
  logic [31:0]   m_cmp;
  int            m_cyc;
  bit            m_pend;
  bit            m_mprev;
  logic [NX-1:0] m_hist [SS];
  int            m_state;  // 0 idle, 1 requesting, 2 in service

  cp0_timer_intc #(.PRESCALE(P), .N_EXT(NX), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .status    (status),
    .cp0_rd    (cp0_rd),
    .cp0_wdata (cp0_wdata),
    .mtc0      (mtc0),
    .eret      (eret),
    .irq_ext   (irq_ext),
    .intr_ack  (intr_ack),
    .intr_req  (intr_req),
    .ip        (ip),
    .timer_int (timer_int),
    .rdata     (rdata),
    .rd_hit    (rd_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / P);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0] v;
    v = '0;
    v[7] = m_pend;
    v[2 +: NX] = m_hist[SS-1];
    return v;
  endfunction

  task automatic model_reset();
    m_base  = '0;
    m_cmp   = 32'hFFFF_FFFF;
    m_cyc   = 0;
    m_pend  = 0;
    m_mprev = 1;
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
    m_state = 0;
  endtask

  task automatic model_step();
    logic [31:0] c;
    logic [7:0]  ipv;
    bit          match;
    bit          any;
    int          ns;
    c     = m_count();
    match = (c == m_cmp);
    ipv   = m_ip();
    any   = status[0] && ((ipv & status[15:8]) != 8'h00);
    ns    = m_state;
    case (m_state)
      0: if (any) ns = 1;
      1: begin
        if (intr_ack) ns = 2;
        else if (!any) ns = 0;
      end
      2: if (eret) ns = 0;
      default: ns = 0;
    endcase
    if (mtc0 && cp0_rd == 5'd11) m_pend = 0;
    else if (match && !m_mprev) m_pend = 1;
    m_mprev = match;
    if (mtc0 && cp0_rd == 5'd9) begin
      m_base = cp0_wdata;
      m_cyc  = 0;
    end else begin
      m_cyc++;
    end
    if (mtc0 && cp0_rd == 5'd11) m_cmp = cp0_wdata;
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = irq_ext;
    m_state = ns;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_rd;
    exp_rd = (cp0_rd == 5'd9) ? m_count() : (cp0_rd == 5'd11) ? m_cmp : 32'h0;
    chk({tag, ".intr_req"},  32'(intr_req),  32'(m_state == 1));
    chk({tag, ".ip"},        32'(ip),        32'(m_ip()));
    chk({tag, ".timer_int"}, 32'(timer_int), 32'(m_pend));
    chk({tag, ".rd_hit"},    32'(rd_hit),    32'(cp0_rd == 5'd9 || cp0_rd == 5'd11));
    chk({tag, ".rdata"},     rdata,          exp_rd);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    mtc0     = 1'b0;
    intr_ack = 1'b0;
    eret     = 1'b0;
    check_outputs(tag);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    cp0_rd    = rd;
    cp0_wdata = data;
    mtc0      = 1'b1;
    step("mtc0");
  endtask

  initial begin
    int n;
    rst = 1'b1; status = '0; cp0_rd = 5'd9; cp0_wdata = '0;
    mtc0 = 1'b0; eret = 1'b0; irq_ext = '0; intr_ack = 1'b0;
    model_reset();
    #12;
    chk("reset.intr_req", 32'(intr_req), 32'd0);
    chk("reset.ip", 32'(ip), 32'd0);
    chk("reset.timer_int", 32'(timer_int), 32'd0);
    chk("reset.count", rdata, 32'd0);
    cp0_rd = 5'd11;
    #1;
    chk("reset.compare", rdata, 32'hFFFF_FFFF);
    cp0_rd = 5'd9;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step("free_run");
    chk("count_after_10", rdata, 32'd5);

    wr(5'd11, 32'h0000_1000);
    wr(5'd9, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) step("wrap");
    chk("wrap.count", rdata, 32'd0);
    chk("wrap.no_pending", 32'(ip[7]), 32'd0);

    status = 32'h0000_8001;
    wr(5'd11, 32'd20);
    wr(5'd9, 32'd18);
    n = 0;
    while (ip[7] !== 1'b1 && n < 20) begin step("timer_wait"); n++; end
    chk("timer.ip7_rise", 32'(ip[7]), 32'd1);
    chk("timer.count_at_rise", rdata, 32'd20);
    chk("timer.req_not_yet", 32'(intr_req), 32'd0);
    step("timer_req");
    chk("timer.req_rise", 32'(intr_req), 32'd1);
    intr_ack = 1'b1;
    step("timer_ack");
    chk("timer.req_after_ack", 32'(intr_req), 32'd0);
    for (int i = 0; i < 3; i++) step("timer_serv");
    chk("timer.serv_blocks", 32'(intr_req), 32'd0);
    wr(5'd11, 32'd100);
    chk("timer.compare_clears", 32'(ip[7]), 32'd0);
    eret = 1'b1;
    step("timer_eret");
    step("timer_idle");

    status  = 32'h0000_0401;
    irq_ext = 5'b00001;
    step("ext_a1");
    chk("ext.req_c1", 32'(intr_req), 32'd0);
    step("ext_a2");
    chk("ext.ip2_c2", 32'(ip[2]), 32'd1);
    step("ext_a3");
    chk("ext.req_c3", 32'(intr_req), 32'd1);
    irq_ext = 5'b00000;
    step("ext_d1");
    step("ext_d2");
    chk("ext.req_held_d2", 32'(intr_req), 32'd1);
    step("ext_d3");
    chk("ext.req_drop_d3", 32'(intr_req), 32'd0);

    status = 32'h0;
    wr(5'd9, 32'd6);
    step("same_pre");
    wr(5'd9, 32'd7);
    chk("same.write_beats_tick", rdata, 32'd7);
    step("same_hold");
    chk("same.prescaler_restart", rdata, 32'd7);
    step("same_inc");
    chk("same.increment", rdata, 32'd8);

    wr(5'd11, 32'd50);
    wr(5'd9, 32'd48);
    n = 0;
    while (m_count() != 32'd50 && n < 20) begin step("cmp_wait"); n++; end
    chk("cmp.reached_match", rdata, 32'd50);
    wr(5'd11, 32'd200);
    chk("cmp.clear_beats_set", 32'(ip[7]), 32'd0);
    step("cmp_after");
    chk("cmp.still_clear", 32'(ip[7]), 32'd0);

    status = 32'h0000_8000;
    wr(5'd9, 32'd300);
    wr(5'd11, 32'd302);
    n = 0;
    while (ip[7] !== 1'b1 && n < 20) begin step("mask_wait"); n++; end
    chk("mask.ip7", 32'(ip[7]), 32'd1);
    step("mask_hold");
    chk("mask.ie_off", 32'(intr_req), 32'd0);
    status = 32'h0000_8001;
    step("mask_ie_on");
    chk("mask.ie_on_req", 32'(intr_req), 32'd1);
    intr_ack = 1'b1;
    step("mask_ack");
    step("mask_serv");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid.intr_req", 32'(intr_req), 32'd0);
    chk("rst_mid.ip", 32'(ip), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    status  = 32'h0000_0401;
    irq_ext = 5'b00001;
    step("post_rst1");
    step("post_rst2");
    step("post_rst3");
    chk("post_rst.idle_rerequest", 32'(intr_req), 32'd1);
    irq_ext = 5'b00000;
    for (int i = 0; i < 3; i++) step("post_rst_drop");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) irq_ext = NX'($urandom);
      if ($urandom_range(0, 7) == 0) status = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        cp0_rd    = ($urandom_range(0, 1) == 0) ? 5'd9 : 5'd11;
        cp0_wdata = 32'($urandom_range(0, 40));
        mtc0      = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          0: cp0_rd = 5'd9;
          1: cp0_rd = 5'd11;
          2: cp0_rd = 5'd12;
          default: cp0_rd = 5'($urandom);
        endcase
      end
      intr_ack = ($urandom_range(0, 3) == 0);
      eret     = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
